// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter sharing the register-file write port
// among three writeback requesters (0 = ALU, 1 = load, 2 = debug).
// The winner is registered onto rf_wa/rf_wd/rf_we one cycle after its
// transfer, and cycles with contention are counted in a saturating counter.
// Build option: define RF_ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2
// (the round-robin pointer is then a constant 0).
module rf_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          hold,
  input  logic          req0_valid,
  input  logic          req1_valid,
  input  logic          req2_valid,
  output logic          req0_ready,
  output logic          req1_ready,
  output logic          req2_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [AW-1:0] req1_addr,
  input  logic [AW-1:0] req2_addr,
  input  logic [DW-1:0] req0_data,
  input  logic [DW-1:0] req1_data,
  input  logic [DW-1:0] req2_data,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          rf_we,
  output logic [1:0]    grant_id,
  output logic [CW-1:0] contention_cnt
);

  localparam logic [1:0] IDLE_ID = 2'd3;

  // Successor of a requester index in the circular order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Bit 3 is a constant 0 so an index of 3 can never select a live valid.
  logic [3:0]    valid_vec;
  logic          multi_valid;
  logic [1:0]    ptr;
  logic [1:0]    cur;
  logic          grant;
  logic [1:0]    win;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  assign valid_vec   = {1'b0, req2_valid, req1_valid, req0_valid};
  assign multi_valid = (req0_valid & req1_valid) | (req0_valid & req2_valid) |
                       (req1_valid & req2_valid);

  // Pick the first valid requester starting from ptr; nothing is granted
  // during reset or hold.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant = 1'b0;
    win   = 2'd0;
    cur   = ptr;
    if (rstn && !hold) begin
      for (int k = 0; k < 3; k++) begin
        if (!grant && valid_vec[cur]) begin
          grant = 1'b1;
          win   = cur;
        end
        cur = next_idx(cur);
      end
    end
  end

  assign req0_ready = grant && (win == 2'd0);
  assign req1_ready = grant && (win == 2'd1);
  assign req2_ready = grant && (win == 2'd2);

  // Route the winner's address and data to the output stage.
  always_comb begin
    win_addr = req0_addr;
    win_data = req0_data;
    case (win)
      2'd1: begin
        win_addr = req1_addr;
        win_data = req1_data;
      end
      2'd2: begin
        win_addr = req2_addr;
        win_data = req2_data;
      end
      default: begin
        win_addr = req0_addr;
        win_data = req0_data;
      end
    endcase
  end

`ifdef RF_ARB_FIXED_PRIO_EN
  assign ptr = 2'd0;
`else
  // Rotate priority to just past the last winner; frozen when idle or held.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rstn) begin
      ptr <= 2'd0;
    end else if (grant) begin
      ptr <= next_idx(win);
    end
  end
`endif

  // Register the winning write onto the register-file port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: rf_wa/rf_wd are datapath registers but are reset anyway
      // because bypass logic can observe them right after reset.
      rf_wa    <= '0;
      rf_wd    <= '0;
      rf_we    <= 1'b0;
      grant_id <= IDLE_ID;
    end else if (grant) begin
      rf_wa    <= win_addr;
      rf_wd    <= win_data;
      rf_we    <= (win_addr != '0);
      grant_id <= win;
    end else begin
      rf_we    <= 1'b0;
      grant_id <= IDLE_ID;
    end
  end

  // Count granted cycles that had competing requesters; saturates.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      contention_cnt <= '0;
    end else if (grant && multi_valid && (contention_cnt != '1)) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter.
// Inputs are driven 1 time unit after posedge, ready is checked 1 unit
// later, registered outputs are checked 1 unit after the following posedge.
module tb_rf_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rstn;
  logic          hold;
  logic          req0_valid, req1_valid, req2_valid;
  logic          req0_ready, req1_ready, req2_ready;
  logic [AW-1:0] req0_addr, req1_addr, req2_addr;
  logic [DW-1:0] req0_data, req1_data, req2_data;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          rf_we;
  logic [1:0]    grant_id;
  logic [CW-1:0] contention_cnt;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .hold(hold),
    .req0_valid(req0_valid), .req1_valid(req1_valid), .req2_valid(req2_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready), .req2_ready(req2_ready),
    .req0_addr(req0_addr), .req1_addr(req1_addr), .req2_addr(req2_addr),
    .req0_data(req0_data), .req1_data(req1_data), .req2_data(req2_data),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
    .grant_id(grant_id), .contention_cnt(contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0; req1_valid = 1'b0; req2_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_reqs();
    hold = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  function automatic logic [2:0] ready_vec();
    return {req2_ready, req1_ready, req0_ready};
  endfunction

  initial begin
    rstn = 1'b0; hold = 1'b0;
    clear_reqs();
    req0_addr = '0; req1_addr = '0; req2_addr = '0;
    req0_data = '0; req1_data = '0; req2_data = '0;

    // Reset state, with requests pending during reset
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1; req2_valid = 1'b1;
    req0_addr = 5'd7;
    #1;
    check("rst_ready", ready_vec(), 3'b000);
    tick();
    check("rst_we", rf_we, 0);
    check("rst_wa", rf_wa, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_gid", grant_id, 3);
    check("rst_cnt", contention_cnt, 0);
    do_reset();

    // Single requester
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hDEADBEEF;
    #1;
    check("single_ready", ready_vec(), 3'b010);
    tick();
    clear_reqs();
    check("single_we", rf_we, 1);
    check("single_wa", rf_wa, 5);
    check("single_wd", rf_wd, 32'hDEADBEEF);
    check("single_gid", grant_id, 1);
    check("single_cnt", contention_cnt, 0);
    tick();
    check("idle_we", rf_we, 0);
    check("idle_gid", grant_id, 3);
    check("idle_wa_hold", rf_wa, 5);

    // Full contention from reset
    do_reset();
    req0_addr = 5'd1; req1_addr = 5'd2; req2_addr = 5'd3;
    req0_data = 32'hA0; req1_data = 32'hA1; req2_data = 32'hA2;
    req0_valid = 1'b1; req1_valid = 1'b1; req2_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_id;
`ifdef RF_ARB_FIXED_PRIO_EN
      exp_id = 2'd0;
`else
      exp_id = 2'(k % 3);
`endif
      #1;
      check("cont_ready", ready_vec(), 3'b001 << exp_id);
      tick();
      check("cont_gid", grant_id, exp_id);
      check("cont_wa", rf_wa, exp_id + 1);
      check("cont_we", rf_we, 1);
    end
    check("cont_cnt", contention_cnt, 6);
    clear_reqs();

    // Write to x0: accepted, no write, pointer advances
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1234;
    #1;
    check("x0_ready", ready_vec(), 3'b001);
    tick();
    check("x0_we", rf_we, 0);
    check("x0_gid", grant_id, 0);
    check("x0_wd", rf_wd, 32'h1234);
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h55;
    #1;
`ifdef RF_ARB_FIXED_PRIO_EN
    check("x0_next_ready", ready_vec(), 3'b001);
`else
    check("x0_next_ready", ready_vec(), 3'b010);
`endif
    tick();
    clear_reqs();
`ifdef RF_ARB_FIXED_PRIO_EN
    check("x0_next_gid", grant_id, 0);
`else
    check("x0_next_gid", grant_id, 1);
`endif
    check("x0_next_cnt", contention_cnt, 1);

    // Hold: pointer set to 1 by a req0 grant, then req2 held off 3 cycles
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h40;
    tick();
    clear_reqs();
    tick();
    hold = 1'b1;
    req2_valid = 1'b1; req2_addr = 5'd6; req2_data = 32'h66;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", ready_vec(), 3'b000);
      tick();
      check("hold_we", rf_we, 0);
      check("hold_gid", grant_id, 3);
    end
    hold = 1'b0;
    req0_valid = 1'b1;
    #1;
`ifdef RF_ARB_FIXED_PRIO_EN
    check("hold_rel_ready", ready_vec(), 3'b001);
`else
    check("hold_rel_ready", ready_vec(), 3'b100);
`endif
    tick();
    clear_reqs();
`ifdef RF_ARB_FIXED_PRIO_EN
    check("hold_rel_gid", grant_id, 0);
    check("hold_rel_wa", rf_wa, 4);
`else
    check("hold_rel_gid", grant_id, 2);
    check("hold_rel_wa", rf_wa, 6);
`endif
    check("hold_rel_we", rf_we, 1);

    // Reset mid-operation drops the in-flight write
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 5'd3; req1_addr = 5'd8;
    tick();
    check("midrst_pre_cnt", contention_cnt, 1);
    req1_valid = 1'b0;
    #1;
    check("midrst_ready", ready_vec(), 3'b001);
    rstn = 1'b0;
    #1;
    check("midrst_ready_rst", ready_vec(), 3'b000);
    tick();
    check("midrst_we", rf_we, 0);
    check("midrst_gid", grant_id, 3);
    check("midrst_cnt", contention_cnt, 0);
    check("midrst_wa", rf_wa, 0);
    rstn = 1'b1;
    clear_reqs();

    // Saturation of the 4-bit contention counter
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 5'd1; req1_addr = 5'd2;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 14) check("sat_cnt_15", contention_cnt, 15);
    end
    check("sat_cnt_final", contention_cnt, 15);
    clear_reqs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
